ahb_cache_arbiter: RTL and testbench

Two-master AHB-Lite arbiter that sits directly downstream of the instruction cache controller and the data cache controller and shares the single external bus between them. It grants the address phase to one cache at a time and holds the grant for a whole multi-beat line fill. It tracks which master owns the pipelined data phase and returns HREADY to that master only, as BusReadyF or BusReadyM. Read data is passed through unregistered.

---
 rtl/ahb_cache_arbiter.sv | 79 +++++++
 tb/tb_ahb_cache_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cache_arbiter.sv
// Two-master AHB-Lite arbiter between the instruction cache (F) and data cache (M) controllers.
// Holds the grant for whole line fills and steers HREADY to the owner of the pipelined data phase.
module ahb_cache_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        HRequestF,
   input  logic [31:0] HAddrF,
   input  logic        HRequestM,
   input  logic        HWriteM,
   input  logic [31:0] HAddrM,
   input  logic [31:0] HWDataM,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   output logic        HRequest,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   output logic        BusReadyF,
   output logic        BusReadyM,
   output logic [31:0] HRDataF,
   output logic [31:0] HRDataM,
   output logic        GrantF,
   output logic        GrantM
);
   // state   | meaning
   // IDLE    | no owner, bus address phase idle
   // GRANT_F | instruction cache owns the address phase
   // GRANT_M | data cache owns the address phase
   typedef enum logic [1:0] {IDLE, GRANT_F, GRANT_M} state_t;

   state_t state, state_nxt;
   logic   data_valid;
   logic   data_owner;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         data_valid <= 1'b0;
         data_owner <= 1'b0;
      end else begin
         state <= state_nxt;
         if (HREADY) begin
            data_valid <= HRequest;
            data_owner <= (state == GRANT_M);
         end
      end
   end

   // Release only happens once the owner's request has dropped and the bus is ready,
   // so a line fill is never split; the other side wins at release.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (HRequestM)      state_nxt = GRANT_M;
            else if (HRequestF) state_nxt = GRANT_F;
         end
         GRANT_F: begin
            if (!HRequestF && HREADY) state_nxt = HRequestM ? GRANT_M : IDLE;
         end
         GRANT_M: begin
            if (!HRequestM && HREADY) state_nxt = HRequestF ? GRANT_F : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Gating with reset keeps the bus quiet while reset is held, even before the first edge.
   assign GrantF    = ~reset & (state == GRANT_F);
   assign GrantM    = ~reset & (state == GRANT_M);
   assign HRequest  = (GrantF & HRequestF) | (GrantM & HRequestM);
   assign HADDR     = GrantM ? HAddrM : HAddrF;
   assign HWRITE    = GrantM & HWriteM & HRequestM;
   assign HWDATA    = HWDataM;
   assign BusReadyF = ~reset & HREADY & data_valid & ~data_owner;
   assign BusReadyM = ~reset & HREADY & data_valid & data_owner;
   assign HRDataF   = HRDATA;
   assign HRDataM   = HRDATA;
endmodule

// File: tb/tb_ahb_cache_arbiter.sv
// Scoreboard bench for ahb_cache_arbiter: owner-level reference model plus a queue of
// accepted transfers that a separate monitor retires against BusReadyF/BusReadyM.
module tb_ahb_cache_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        HRequestF, HRequestM, HWriteM, HREADY;
   logic [31:0] HAddrF, HAddrM, HWDataM, HRDATA;
   logic        HRequest, HWRITE, BusReadyF, BusReadyM, GrantF, GrantM;
   logic [31:0] HADDR, HWDATA, HRDataF, HRDataM;

   ahb_cache_arbiter dut (
      .clk(clk), .reset(reset),
      .HRequestF(HRequestF), .HAddrF(HAddrF),
      .HRequestM(HRequestM), .HWriteM(HWriteM), .HAddrM(HAddrM), .HWDataM(HWDataM),
      .HREADY(HREADY), .HRDATA(HRDATA),
      .HRequest(HRequest), .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .BusReadyF(BusReadyF), .BusReadyM(BusReadyM),
      .HRDataF(HRDataF), .HRDataM(HRDataM),
      .GrantF(GrantF), .GrantM(GrantM)
   );

   always #5 clk = ~clk;

   typedef enum {O_NONE, O_F, O_M} own_t;

   int   checks = 0;
   int   failures = 0;
   own_t own = O_NONE;
   bit   q[$];
   bit   alt_seq[$];
   bit   alt_log = 1'b0;
   bit   running = 1'b0;
   int   rem_f = 0, rem_m = 0;
   int   rdy_f_cnt = 0, rdy_m_cnt = 0;

   task automatic check1(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // One bus cycle: compare address-side outputs mid-cycle, then advance the model at the edge.
   task automatic step();
      bit e_f, e_m, e_req;
      @(negedge clk);
      e_f   = !reset && own == O_F;
      e_m   = !reset && own == O_M;
      e_req = (e_f && HRequestF) || (e_m && HRequestM);
      check1("GrantF", GrantF, e_f);
      check1("GrantM", GrantM, e_m);
      check1("HRequest", HRequest, e_req);
      check32("HADDR", HADDR, e_m ? HAddrM : HAddrF);
      check1("HWRITE", HWRITE, e_m && HRequestM && HWriteM);
      check32("HWDATA", HWDATA, HWDataM);
      @(posedge clk);
      if (reset) begin
         own = O_NONE;
         q.delete();
         rem_f = 0;
         rem_m = 0;
      end else begin
         if (HREADY && e_req) begin
            q.push_back(e_m);
            if (e_m && rem_m > 0) rem_m--;
            if (e_f && rem_f > 0) rem_f--;
         end
         case (own)
            O_NONE: own = HRequestM ? O_M : (HRequestF ? O_F : O_NONE);
            O_F:    if (!HRequestF && HREADY) own = HRequestM ? O_M : O_NONE;
            O_M:    if (!HRequestM && HREADY) own = HRequestF ? O_F : O_NONE;
            default: own = O_NONE;
         endcase
      end
      #1;
   endtask

   // A cache raises a new burst only when it is not the current owner, as it must drop
   // its request for at least the release cycle.
   task automatic drive_bursts(int maxlen, bit rand_rdy, bit rand_rst);
      if (rem_f == 0 && own != O_F && (maxlen == 1 || $urandom_range(3) == 0))
         rem_f = int'($urandom_range(maxlen, 1));
      if (rem_m == 0 && own != O_M && (maxlen == 1 || $urandom_range(3) == 0)) begin
         rem_m   = int'($urandom_range(maxlen, 1));
         HWriteM = ($urandom_range(1) == 1);
      end
      HRequestF = (rem_f > 0);
      HRequestM = (rem_m > 0);
      HAddrF    = $urandom;
      HAddrM    = $urandom;
      HWDataM   = $urandom;
      HRDATA    = $urandom;
      HREADY    = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
      reset     = rand_rst && ($urandom_range(299) == 0);
   endtask

   task automatic go_idle();
      HRequestF = 1'b0;
      HRequestM = 1'b0;
      HREADY    = 1'b1;
      rem_f     = 0;
      rem_m     = 0;
      repeat (3) step();
   endtask

   always @(negedge clk) begin
      bit ef, em;
      if (running) begin
         ef = 1'b0;
         em = 1'b0;
         if (!reset && HREADY && q.size() > 0) begin
            ef = !q[0];
            em = q[0];
         end
         check1("BusReadyF", BusReadyF, ef);
         check1("BusReadyM", BusReadyM, em);
         check32("HRDataF", HRDataF, HRDATA);
         check32("HRDataM", HRDataM, HRDATA);
         if (BusReadyF) rdy_f_cnt++;
         if (BusReadyM) rdy_m_cnt++;
         if (alt_log && (BusReadyF || BusReadyM)) alt_seq.push_back(BusReadyM);
         if (ef || em) void'(q.pop_front());
      end
   end

   initial begin
      int base_f, base_m;
      reset = 1'b1;
      HRequestF = 1'b1; HRequestM = 1'b1; HWriteM = 1'b1; HREADY = 1'b1;
      HAddrF = 32'h55; HAddrM = 32'hAA; HWDataM = 32'h0; HRDATA = 32'h0;
      #1 running = 1'b1;
      repeat (2) step();

      // Single fill from F straight out of reset
      reset = 1'b0; HRequestM = 1'b0; HWriteM = 1'b0;
      HRequestF = 1'b1; HAddrF = 32'h100; HREADY = 1'b1;
      base_m = rdy_m_cnt;
      step();
      check1("tp1_hrequest_c1", HRequest, 1'b1);
      check32("tp1_haddr_c1", HADDR, 32'h100);
      step();
      check1("tp1_busreadyF_c2", BusReadyF, 1'b1);
      repeat (2) step();
      go_idle();
      check32("tp1_no_busreadyM", 32'(rdy_m_cnt - base_m), 32'd0);

      // Simultaneous requests: M first, F after release
      HRequestF = 1'b1; HRequestM = 1'b1; HAddrF = 32'h200; HAddrM = 32'h300;
      step();
      check1("tp2_grantM_first", GrantM, 1'b1);
      repeat (2) step();
      HRequestM = 1'b0;
      step();
      check1("tp2_grantF_after", GrantF, 1'b1);
      step();
      go_idle();

      // Four-beat instruction fill with a data request arriving mid-fill
      HRequestF = 1'b1; HAddrF = 32'h400;
      step();
      base_f = rdy_f_cnt;
      for (int b = 0; b < 4; b++) begin
         if (b == 1) HRequestM = 1'b1;
         HAddrF = 32'h400 + 32'(b * 4);
         step();
      end
      HRequestF = 1'b0;
      step();
      check32("tp3_four_busreadyF", 32'(rdy_f_cnt - base_f), 32'd4);
      check1("tp3_grantM_after", GrantM, 1'b1);
      step();
      go_idle();

      // Data-cache write stalled by three wait states
      HRequestM = 1'b1; HWriteM = 1'b1; HAddrM = 32'h800; HWDataM = 32'hDEADBEEF;
      step();
      step();
      base_m = rdy_m_cnt;
      HREADY = 1'b0;
      repeat (3) step();
      check32("tp4_hwdata_stable", HWDATA, 32'hDEADBEEF);
      check32("tp4_no_ready_in_wait", 32'(rdy_m_cnt - base_m), 32'd0);
      HREADY = 1'b1; HRequestM = 1'b0;
      step();
      check32("tp4_one_busreadyM", 32'(rdy_m_cnt - base_m), 32'd1);
      HWriteM = 1'b0;
      go_idle();

      // Reset while the data cache owns an outstanding data phase
      HRequestM = 1'b1; HAddrM = 32'hC00;
      step();
      step();
      base_m = rdy_m_cnt;
      reset = 1'b1;
      step();
      reset = 1'b0; HRequestM = 1'b0;
      step();
      check32("tp5_no_busreadyM", 32'(rdy_m_cnt - base_m), 32'd0);
      go_idle();

      // Continuous single-beat requests from both sides must alternate
      alt_seq.delete();
      alt_log = 1'b1;
      for (int c = 0; c < 30; c++) begin
         drive_bursts(1, 1'b0, 1'b0);
         step();
      end
      go_idle();
      alt_log = 1'b0;
      check1("tp6_enough_grants", alt_seq.size() >= 8, 1'b1);
      for (int i = 1; i < alt_seq.size(); i++)
         check1("tp6_alternation", alt_seq[i], !alt_seq[i-1]);

      // Random bursts, wait states and occasional resets
      for (int c = 0; c < 3000; c++) begin
         drive_bursts(4, 1'b1, 1'b1);
         step();
      end
      reset = 1'b0;
      go_idle();
      check32("queue_drained", 32'(q.size()), 32'd0);

      running = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
